// File: rtl/stream_pkg.sv
// Shared constants for the serial stream front end and the 1010 detector bench.
package stream_pkg;

   localparam int unsigned DEF_DATA_W      = 8;
   localparam logic        STREAM_IDLE_BIT = 1'b0;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: one-word hold buffer feeding a shift register,
// gapless across back-to-back words, idle level and underrun flag otherwise.
module bit_stream_serializer
   import stream_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = STREAM_IDLE_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              word_done,
   output logic              underrun,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [0:0]        r_state;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_underrun;

   logic              w_accept;
   logic              w_last;
   logic              w_cur_bit;
   logic [DATA_W-1:0] w_shift_next;

   assign w_accept     = in_valid && !r_hold_full;
   assign w_last       = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_CNT);
   assign w_cur_bit    = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
   assign w_shift_next = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                   : {1'b0, r_shift[DATA_W-1:1]};

   // Accept and hold-to-shift load are mutually exclusive: accept needs hold empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (w_accept) begin
            r_hold      <= in_data;
            r_hold_full <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (r_hold_full) begin
                  r_shift     <= r_hold;
                  r_hold_full <= 1'b0;
                  r_bit_cnt   <= '0;
                  r_state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_last) begin
                  r_bit_cnt <= '0;
                  if (r_hold_full) begin
                     r_shift     <= r_hold;
                     r_hold_full <= 1'b0;
                  end else begin
                     r_shift    <= w_shift_next;
                     r_state    <= ST_IDLE;
                     r_underrun <= 1'b1;
                  end
               end else begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = !r_hold_full;
   assign dout       = (r_state == ST_SHIFT) ? w_cur_bit : IDLE_BIT;
   assign dout_valid = (r_state == ST_SHIFT);
   assign word_done  = w_last;
   assign underrun   = r_underrun;
   assign busy       = (r_state == ST_SHIFT) || r_hold_full;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: three parameterisations, immediate assertions.
module tb_bit_stream_serializer;
   import stream_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // a: DATA_W=8 MSB first, b: DATA_W=8 LSB first, c: DATA_W=2 MSB first
   logic [7:0] a_data = '0;
   logic       a_valid = 1'b0;
   logic       a_rdy, a_dout, a_dv, a_wd, a_ur, a_busy;
   logic [7:0] b_data = '0;
   logic       b_valid = 1'b0;
   logic       b_rdy, b_dout, b_dv, b_wd, b_ur, b_busy;
   logic [1:0] c_data = '0;
   logic       c_valid = 1'b0;
   logic       c_rdy, c_dout, c_dv, c_wd, c_ur, c_busy;

   int n_assert = 0;
   int n_fail   = 0;

   bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(STREAM_IDLE_BIT)) u_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
      .dout(a_dout), .dout_valid(a_dv), .word_done(a_wd), .underrun(a_ur), .busy(a_busy));

   bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(STREAM_IDLE_BIT)) u_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
      .dout(b_dout), .dout_valid(b_dv), .word_done(b_wd), .underrun(b_ur), .busy(b_busy));

   bit_stream_serializer #(.DATA_W(2), .MSB_FIRST(1'b1), .IDLE_BIT(STREAM_IDLE_BIT)) u_c (
      .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
      .dout(c_dout), .dout_valid(c_dv), .word_done(c_wd), .underrun(c_ur), .busy(c_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Non-overlapping 1010 detector reference; returns mask with bit (pos-1) set per hit.
   function automatic logic [7:0] det1010(input logic [7:0] bits);
      logic [3:0] pat;
      int unsigned m;
      logic b;
      logic [7:0] hits;
      pat  = 4'b1010;
      m    = 0;
      hits = '0;
      for (int i = 0; i < 8; i++) begin
         b = bits[7-i];
         if (b == pat[3-m]) m++;
         else m = b ? 1 : 0;
         if (m == 4) begin
            hits[i] = 1'b1;
            m = 0;
         end
      end
      return hits;
   endfunction

   task automatic send_a(input logic [7:0] d, output logic [7:0] bits, output int nvalid);
      int k;
      a_data  = d;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      k = 0;
      while (!a_dv && k < 8) begin
         tick();
         k++;
      end
      chk("send_start", {31'd0, a_dv}, 32'd1);
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         bits[7-i] = a_dout;
         if (a_dv) nvalid++;
         tick();
      end
      tick();
   endtask

   initial begin
      logic [7:0]  w8;
      logic [15:0] w16;
      logic [7:0]  got;
      int          nv;
      int          vcnt;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", {31'd0, a_dout}, 32'd0);
      chk("rst_dv", {31'd0, a_dv}, 32'd0);
      chk("rst_rdy", {31'd0, a_rdy}, 32'd1);
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_wd_ur", {30'd0, a_wd, a_ur}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: single word A5, MSB first
      w8 = 8'hA5;
      a_data  = w8;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("t1_e0_rdy", {31'd0, a_rdy}, 32'd0);
      chk("t1_e0_busy", {31'd0, a_busy}, 32'd1);
      chk("t1_e0_dv", {31'd0, a_dv}, 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t1_bit", {31'd0, a_dout}, {31'd0, w8[7-i]});
         chk("t1_dv", {31'd0, a_dv}, 32'd1);
         chk("t1_wd", {31'd0, a_wd}, (i == 7) ? 32'd1 : 32'd0);
         chk("t1_ur_in", {31'd0, a_ur}, 32'd0);
         tick();
      end
      chk("t1_end_dv", {31'd0, a_dv}, 32'd0);
      chk("t1_end_dout", {31'd0, a_dout}, 32'd0);
      chk("t1_end_ur", {31'd0, a_ur}, 32'd1);
      chk("t1_end_busy", {31'd0, a_busy}, 32'd0);
      tick();
      chk("t1_ur_clr", {31'd0, a_ur}, 32'd0);

      // 2: back-to-back AA, 55
      w16 = 16'hAA55;
      a_data  = 8'hAA;
      a_valid = 1'b1;
      tick();
      a_data = 8'h55;
      chk("t2_e0_rdy", {31'd0, a_rdy}, 32'd0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t2_bit", {31'd0, a_dout}, {31'd0, w16[15-i]});
         chk("t2_dv", {31'd0, a_dv}, 32'd1);
         chk("t2_ur", {31'd0, a_ur}, 32'd0);
         if (i == 0 || i == 8) chk("t2_rdy_hi", {31'd0, a_rdy}, 32'd1);
         if (i == 1) chk("t2_rdy_lo", {31'd0, a_rdy}, 32'd0);
         if (i == 1) a_valid = 1'b0;
         tick();
      end
      chk("t2_end_dv", {31'd0, a_dv}, 32'd0);
      chk("t2_end_ur", {31'd0, a_ur}, 32'd1);
      tick();

      // 3: detector on streamed words
      send_a(8'hAA, got, nv);
      chk("t3_aa_bits", {24'd0, got}, 32'hAA);
      chk("t3_aa_nv", nv, 32'd8);
      chk("t3_aa_hits", {24'd0, det1010(got)}, 32'h88);
      send_a(8'hA5, got, nv);
      chk("t3_a5_bits", {24'd0, got}, 32'hA5);
      chk("t3_a5_hits", {24'd0, det1010(got)}, 32'h08);

      // 4: data changed while hold full is not captured
      w16 = 16'hAA3C;
      a_data  = 8'hAA;
      a_valid = 1'b1;
      tick();
      a_data = 8'h3C;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t4_bit", {31'd0, a_dout}, {31'd0, w16[15-i]});
         chk("t4_dv", {31'd0, a_dv}, 32'd1);
         if (i == 1) a_data = 8'hFF;
         if (i >= 1 && i <= 4) chk("t4_rdy_lo", {31'd0, a_rdy}, 32'd0);
         if (i >= 1 && i <= 4) chk("t4_busy", {31'd0, a_busy}, 32'd1);
         if (i == 5) a_valid = 1'b0;
         tick();
      end
      chk("t4_end_dv", {31'd0, a_dv}, 32'd0);
      chk("t4_end_ur", {31'd0, a_ur}, 32'd1);
      tick();

      // 5: reset during 3rd bit of F0 with 0F buffered
      a_data  = 8'hF0;
      a_valid = 1'b1;
      tick();
      a_data = 8'h0F;
      tick();
      tick();
      a_valid = 1'b0;
      chk("t5_buffered", {31'd0, a_rdy}, 32'd0);
      tick();
      chk("t5_bit2", {31'd0, a_dout}, 32'd1);
      chk("t5_bit2_dv", {31'd0, a_dv}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_dout", {31'd0, a_dout}, 32'd0);
      chk("t5_rst_dv", {31'd0, a_dv}, 32'd0);
      chk("t5_rst_rdy", {31'd0, a_rdy}, 32'd1);
      chk("t5_rst_busy", {31'd0, a_busy}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (a_dv || a_busy) vcnt++;
      end
      chk("t5_no_emit", vcnt, 32'd0);

      // 6a: LSB first, 01
      w8 = 8'h01;
      b_data  = w8;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t6_lsb_bit", {31'd0, b_dout}, {31'd0, w8[i]});
         chk("t6_lsb_dv", {31'd0, b_dv}, 32'd1);
         chk("t6_lsb_wd", {31'd0, b_wd}, (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
      chk("t6_lsb_end_dv", {31'd0, b_dv}, 32'd0);
      chk("t6_lsb_end_ur", {31'd0, b_ur}, 32'd1);

      // 6b: DATA_W=2 continuous 2'b10
      c_data  = 2'b10;
      c_valid = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 12; i++) begin
         chk("t6_w2_bit", {31'd0, c_dout}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t6_w2_dv", {31'd0, c_dv}, 32'd1);
         chk("t6_w2_ur", {31'd0, c_ur}, 32'd0);
         chk("t6_w2_wd", {31'd0, c_wd}, (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
      end
      c_valid = 1'b0;
      repeat (6) tick();
      chk("t6_w2_drain", {31'd0, c_dv}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial front end that feeds the 1010 sequence detector's `din`.
- Accepts DATA_W-bit words over a valid/ready handshake and buffers one word.
- Shifts words out one bit per clock, gapless across back-to-back words.
- Drives a defined idle level when no data is available and flags stream gaps.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit DATA_W-1 leaves first; 0 = bit 0 leaves first.
- IDLE_BIT, 0: level driven on dout while no word is shifting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DATA_W  parallel word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- dout  out  1  serial bit, connects to detector din.
- dout_valid  out  1  dout carries a data bit this cycle.
- word_done  out  1  1-cycle pulse on the last bit of each word.
- underrun  out  1  1-cycle pulse when a word ends and no next word is buffered.
- busy  out  1  shift in progress or hold buffer full.

Behaviour:
- Reset values (all registers cleared asynchronously):
  - dout=IDLE_BIT; dout_valid=0; word_done=0; underrun=0; busy=0; in_ready=1.
  - FSM=IDLE; hold buffer empty; bit_cnt=0; shift_reg=0.
- Storage:
  - hold_reg (DATA_W) plus hold_full flag.
  - shift_reg (DATA_W).
  - bit_cnt, width clog2(DATA_W); wraps DATA_W-1 -> 0.
- in_ready = !hold_full. It is registered-state derived, with no combinational path from in_valid.
- Accept: on a rising edge with in_valid && in_ready:
  - in_data is captured into hold_reg and hold_full is set.
  - in_data is ignored when in_ready=0. The source must hold the word stable until accepted.
- FSM IDLE:
  - dout=IDLE_BIT, dout_valid=0.
  - If hold_full at the edge: load shift_reg from hold_reg, clear hold_full, set bit_cnt=0, go to SHIFT.
- FSM SHIFT:
  - dout = current bit of shift_reg (MSB or LSB per MSB_FIRST); dout_valid=1.
  - Each edge shifts by one and increments bit_cnt.
- End of word: the cycle with bit_cnt==DATA_W-1 is the last bit and word_done=1 in that cycle. At the closing edge:
  - If hold_full: reload shift_reg, clear hold_full, bit_cnt=0, stay in SHIFT. Output is gapless, so the next word's first bit follows immediately.
  - Else: go to IDLE, and underrun=1 for the cycle after the edge.
- Latency: a word accepted at edge E0 has its first bit on dout in the cycle after E1.
- Simultaneous events:
  - A hold-to-shift load and a new accept cannot occur on the same edge, because in_ready is low while hold_full.
  - The hold buffer refills on the following edge. Since DATA_W>=2, a continuously valid source sustains 100% bit throughput.
- Output timing: dout, dout_valid, word_done and underrun are driven from registers (no combinational input-to-output path).
- busy = (state==SHIFT) || hold_full.
- Reset mid-word: the partial word and the buffered word are discarded. Outputs return to reset values immediately (asynchronously).
- MSB_FIRST=0: the same timing applies, with bit order reversed.

Decomposition:
- Shared package `stream_pkg`:
  - FSM state encoding (IDLE=1'b0, SHIFT=1'b1).
  - Default DATA_W.
  - IDLE_BIT constant shared with the detector bench.
- No sub-module is needed; a single module (~150 lines) suffices.
- Top-level test harness: bit_stream_serializer.dout -> non-overlapping 1010 detector din.

Test Plan:
1. Send 8'hA5, MSB_FIRST=1, single word -> dout=1,0,1,0,0,1,0,1 starting the cycle after E1; dout_valid high exactly 8 cycles; word_done on the 8th bit; underrun pulse next cycle; dout=0 afterward.
2. in_valid held continuously with words 8'hAA,8'h55 -> 16 contiguous valid bits 1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1; no underrun between words; in_ready toggles low/high around each load.
3. Chained into the detector, stream 8'hAA -> detector dout pulses on bit 4 and bit 8 (non-overlapping); stream 8'hA5 -> single pulse on bit 4.
4. in_valid held while hold_full=1 and in_data changed -> in_ready=0, changed value not captured; the originally accepted word is emitted unchanged.
5. Assert rst during the 3rd bit of 8'hF0 with 8'h0F buffered -> dout=0 and dout_valid=0 immediately; in_ready=1; neither word is emitted after rst deasserts.
6. MSB_FIRST=0, send 8'h01 -> dout=1,0,0,0,0,0,0,0; DATA_W=2 continuous 2'b10 stream -> gapless 1,0,1,0,...
